seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Multi-cycle restoring divider: replaces the single-cycle combinational A/B in the ALU datapath.
//   Accepts a Start pulse with operands, iterates one quotient bit per clock, returns Quotient/Remainder with Done.
//   Sits beside the ALU; the ALU Div opcode is served by this block via the Start/Done handshake.
// PARAMETERS
//   WIDTH   4   operand, quotient and remainder width in bits (>=2)
// PORTS
//   Clk        in   1      clock, rising-edge
//   Reset      in   1      asynchronous, active-high; clears all state and outputs
//   Start      in   1      request; sampled only in IDLE
//   Dividend   in   WIDTH  numerator, captured on the accepting edge
//   Divisor    in   WIDTH  denominator, captured on the accepting edge
//   Busy       out  1      high from accepting edge until return to IDLE (RUN and DONE states)
//   Done       out  1      single-cycle pulse, results valid
//   Quotient   out  WIDTH  registered result, held until next Done
//   Remainder  out  WIDTH  registered result, held until next Done
//   DivByZero  out  1      registered; set with Done when captured Divisor==0, cleared at next accept
// BEHAVIOUR
//   - Reset (any time, incl. mid-operation): state IDLE, Busy=0, Done=0, Quotient=0, Remainder=0, DivByZero=0, counter=0.
//   - FSM: IDLE -> (Start) -> RUN (Divisor!=0) or DONE (Divisor==0); RUN -> DONE after WIDTH iterations; DONE -> IDLE.
//   - Accept: edge where state==IDLE && Start; latch operands, Busy=1 after that edge.
//   - RUN: per edge, P={P[WIDTH-1:0],Q[WIDTH-1]}, Q<<=1; T=P-{1'b0,D} (WIDTH+1 bits); if T>=0 then P=T, Q[0]=1.
//   - Latency: Done high in the cycle WIDTH+1 edges after accept (WIDTH RUN edges + DONE entry); Busy for WIDTH+1 cycles.
//   - Divide-by-zero: Done 1 cycle after accept; Quotient={WIDTH{1'b1}}, Remainder=Dividend, DivByZero=1.
//   - Start while Busy (RUN or DONE): ignored, no queuing; operands changing during RUN have no effect.
//   - Quotient/Remainder/DivByZero update only on the edge entering DONE; stable otherwise.
//   - Dividend < Divisor: Quotient=0, Remainder=Dividend. Dividend==0: Quotient=0, Remainder=0.
// CONFIGURATION
//   Macro DIV_SIGNED_EN:
//   - Defined: operands two's complement. Magnitudes computed at accept; unsigned core unchanged;
//     at DONE, Quotient negated if operand signs differ, Remainder takes sign of Dividend (truncate toward zero).
//     Overflow case min/-1: Quotient=min (e.g. 4'b1000), Remainder=0. Div-by-zero result as unsigned case.
//   - Undefined: operands and results unsigned; no sign logic synthesised.
// STRUCTURE
//   - Shared package seq_divider_pkg: state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10;
//     CNT_W=$clog2(WIDTH+1) iteration-counter width constant.
//   - One sub-module div_step: combinational shift/trial-subtract stage (inputs P,Q,D; outputs P_next,Q_next);
//     subtract built as P + ~D + 1 in the same style as the ripple adder.
//   - Top: FSM, counter, operand/result registers, optional sign fixup.
// TESTING (WIDTH=4)
//   - 13/3 unsigned: Start 1 cycle -> Busy 5 cycles, Done in 5th cycle after accept, Quotient=4, Remainder=1, DivByZero=0.
//   - 7/0: Done 1 cycle after accept, Quotient=4'b1111, Remainder=4'b0111, DivByZero=1; next 15/1 clears flag, Q=15, R=0.
//   - Start re-asserted with 2/1 during RUN of 9/2: ignored; result Q=4, R=1; no second Done.
//   - Reset asserted in 2nd RUN cycle of 12/5: outputs 0 immediately (async), IDLE; fresh 12/5 -> Q=2, R=2.
//   - 3/9: Q=0, R=3; back-to-back Start in cycle after Done accepted, Done again after 5 cycles.
//   - DIV_SIGNED_EN: -7/2 -> Q=4'b1101 (-3), R=4'b1111 (-1); -8/-1 -> Q=4'b1000, R=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings and
// iteration-counter sizing.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam int DEF_WIDTH = 4;
   localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

   // Counter width for an arbitrary operand width (counts 0..width).
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left by one
// quotient bit, trial-subtract the divisor, keep the result if non-negative.
module div_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] p,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] p_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH:0]   p_sh;
   logic [WIDTH:0]   t;
   logic [WIDTH-1:0] q_sh;

   assign p_sh = {p, q[WIDTH-1]};
   assign q_sh = {q[WIDTH-2:0], 1'b0};

   // P + ~D + 1; the partial remainder stays below D, so bit WIDTH is a true sign.
   assign t = p_sh + ~{1'b0, d} + {{WIDTH{1'b0}}, 1'b1};

   assign p_next = t[WIDTH] ? p_sh[WIDTH-1:0] : t[WIDTH-1:0];
   assign q_next = {q_sh[WIDTH-1:1], ~t[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock with a Start/Done
// handshake. Define DIV_SIGNED_EN for two's-complement operands (truncating).
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivByZero,
   output logic [1:0]       dbg_state
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state, state_nx;
   logic [WIDTH-1:0] p_reg, q_reg, d_reg;
   logic [WIDTH-1:0] p_next, q_next;
   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH-1:0] q_fix, r_fix;
   logic [CW-1:0]    cnt;
   logic             accept, last, zero_div;

   assign accept   = (state == ST_IDLE) && Start;
   assign last     = (state == ST_RUN) && (cnt == CW'(WIDTH - 1));
   assign zero_div = (Divisor == '0);

`ifdef DIV_SIGNED_EN
   logic neg_q, neg_r;

   // The unsigned core sees magnitudes; min negates to itself, which is its
   // correct unsigned magnitude.
   assign dvd_mag = Dividend[WIDTH-1] ? (~Dividend + ONE) : Dividend;
   assign dvs_mag = Divisor[WIDTH-1]  ? (~Divisor + ONE)  : Divisor;
   assign q_fix   = neg_q ? (~q_next + ONE) : q_next;
   assign r_fix   = neg_r ? (~p_next + ONE) : p_next;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (accept) begin
         neg_q <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
         neg_r <= Dividend[WIDTH-1];
      end
   end
`else
   assign dvd_mag = Dividend;
   assign dvs_mag = Divisor;
   assign q_fix   = q_next;
   assign r_fix   = p_next;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .p      (p_reg),
      .q      (q_reg),
      .d      (d_reg),
      .p_next (p_next),
      .q_next (q_next)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (Start) state_nx = zero_div ? ST_DONE : ST_RUN;
         ST_RUN:  if (last)  state_nx = ST_DONE;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      Busy      = (state == ST_RUN) || (state == ST_DONE);
      Done      = (state == ST_DONE);
      dbg_state = state;
   end

   // Results change only on the edge that enters DONE.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         p_reg     <= '0;
         q_reg     <= '0;
         d_reg     <= '0;
         cnt       <= '0;
         Quotient  <= '0;
         Remainder <= '0;
         DivByZero <= 1'b0;
      end else if (accept) begin
         p_reg     <= '0;
         q_reg     <= dvd_mag;
         d_reg     <= dvs_mag;
         cnt       <= '0;
         DivByZero <= zero_div;
         if (zero_div) begin
            Quotient  <= '1;
            Remainder <= Dividend;
         end
      end else if (state == ST_RUN) begin
         p_reg <= p_next;
         q_reg <= q_next;
         cnt   <= cnt + CW'(1);
         if (last) begin
            Quotient  <= q_fix;
            Remainder <= r_fix;
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (WIDTH=4): latency, busy window,
// divide-by-zero, ignored Start, async reset mid-run, back-to-back operations.
module tb_seq_divider;

`ifdef DIV_SIGNED_EN
   localparam bit SG = 1'b1;
`else
   localparam bit SG = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset, Start;
   logic [3:0] Dividend, Divisor;
   logic       Busy, Done, DivByZero;
   logic [3:0] Quotient, Remainder;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int done_at, busy_n, done_n;

   seq_divider #(.WIDTH(4)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .Busy      (Busy),
      .Done      (Done),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .DivByZero (DivByZero),
      .dbg_state (dbg_state)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle. Issues a one-cycle Start, then
   // watches span cycles; optionally re-asserts Start with 2/1 at inj_cyc.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int span,
                         input int inj_cyc, output int d_at, output int b_n, output int d_n);
      Start = 1'b1; Dividend = a; Divisor = b;
      @(posedge Clk);
      d_at = 0; b_n = 0; d_n = 0;
      for (int cyc = 1; cyc <= span; cyc++) begin
         @(negedge Clk);
         Start = (cyc == inj_cyc);
         if (cyc == inj_cyc) begin
            Dividend = 4'd2; Divisor = 4'd1;
         end
         if (Busy) b_n++;
         if (Done) begin
            d_n++;
            if (d_at == 0) d_at = cyc;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b1; Start = 1'b0; Dividend = '0; Divisor = '0;
      repeat (2) @(negedge Clk);
      check("rst_busy", 8'(Busy), 8'h0);
      check("rst_done", 8'(Done), 8'h0);
      check("rst_quot", 8'(Quotient), 8'h0);
      check("rst_rem", 8'(Remainder), 8'h0);
      check("rst_dbz", 8'(DivByZero), 8'h0);
      check("rst_state", 8'(dbg_state), 8'h0);
      Reset = 1'b0;
      @(negedge Clk);

      // 13/3 (signed: -3/3)
      run_op(4'd13, 4'd3, 7, 0, done_at, busy_n, done_n);
      check("t1_done_at", 8'(done_at), 8'd5);
      check("t1_busy_n", 8'(busy_n), 8'd5);
      check("t1_done_n", 8'(done_n), 8'd1);
      check("t1_quot", 8'(Quotient), SG ? 8'hF : 8'h4);
      check("t1_rem", 8'(Remainder), SG ? 8'h0 : 8'h1);
      check("t1_dbz", 8'(DivByZero), 8'h0);

      // 7/0: divide by zero finishes one cycle after accept
      run_op(4'd7, 4'd0, 3, 0, done_at, busy_n, done_n);
      check("dz_done_at", 8'(done_at), 8'd1);
      check("dz_busy_n", 8'(busy_n), 8'd1);
      check("dz_quot", 8'(Quotient), 8'hF);
      check("dz_rem", 8'(Remainder), 8'h7);
      check("dz_dbz", 8'(DivByZero), 8'h1);

      // 15/1 clears the flag (signed: -1/1 gives the same bit patterns)
      run_op(4'd15, 4'd1, 7, 0, done_at, busy_n, done_n);
      check("t3_done_at", 8'(done_at), 8'd5);
      check("t3_dbz", 8'(DivByZero), 8'h0);
      check("t3_quot", 8'(Quotient), 8'hF);
      check("t3_rem", 8'(Remainder), 8'h0);

      // 9/2 with Start 2/1 re-asserted during RUN (signed: -7/2)
      run_op(4'd9, 4'd2, 10, 2, done_at, busy_n, done_n);
      check("ign_done_n", 8'(done_n), 8'd1);
      check("ign_done_at", 8'(done_at), 8'd5);
      check("ign_quot", 8'(Quotient), SG ? 8'hD : 8'h4);
      check("ign_rem", 8'(Remainder), SG ? 8'hF : 8'h1);

      // 12/5 interrupted by asynchronous reset in the second RUN cycle
      Start = 1'b1; Dividend = 4'd12; Divisor = 4'd5;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      @(negedge Clk);
      check("mid_state_run", 8'(dbg_state), 8'h1);
      #2 Reset = 1'b1;
      #1;
      check("mid_busy", 8'(Busy), 8'h0);
      check("mid_done", 8'(Done), 8'h0);
      check("mid_quot", 8'(Quotient), 8'h0);
      check("mid_rem", 8'(Remainder), 8'h0);
      check("mid_state", 8'(dbg_state), 8'h0);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);

      // fresh 12/5 (signed: -4/5)
      run_op(4'd12, 4'd5, 7, 0, done_at, busy_n, done_n);
      check("t5_done_at", 8'(done_at), 8'd5);
      check("t5_quot", 8'(Quotient), SG ? 8'h0 : 8'h2);
      check("t5_rem", 8'(Remainder), SG ? 8'hC : 8'h2);

      // 3/9 ending on the Done cycle (signed: 3/-7), then back-to-back 14/4 (signed: -2/4)
      run_op(4'd3, 4'd9, 5, 0, done_at, busy_n, done_n);
      check("t6_done_at", 8'(done_at), 8'd5);
      check("t6_quot", 8'(Quotient), 8'h0);
      check("t6_rem", 8'(Remainder), 8'h3);
      @(negedge Clk);
      check("t6_idle", 8'(Busy), 8'h0);
      run_op(4'd14, 4'd4, 6, 0, done_at, busy_n, done_n);
      check("b2b_done_at", 8'(done_at), 8'd5);
      check("b2b_busy_n", 8'(busy_n), 8'd5);
      check("b2b_quot", 8'(Quotient), SG ? 8'h0 : 8'h3);
      check("b2b_rem", 8'(Remainder), SG ? 8'hE : 8'h2);

`ifdef DIV_SIGNED_EN
      // overflow case min/-1
      run_op(4'b1000, 4'b1111, 7, 0, done_at, busy_n, done_n);
      check("ovf_quot", 8'(Quotient), 8'h8);
      check("ovf_rem", 8'(Remainder), 8'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
